// File: rtl/rs_nway.sv
// rs_nway: N-way reservation station between rename/dispatch and the FU
// issue registers.
//
// Each cycle it accepts up to WAYS dispatched instructions and snoops
// CDB_NUM result buses to wake operands. It issues up to WAYS ready
// instructions, one per issue port, subject to per-port FU availability.
//
// Optional feature macro: RS_AGE_PRIORITY_EN
//   defined   : select is oldest-first. Each entry carries an age rank.
//   undefined : select is lowest entry index first. There is no age state.
//
// Ports
//   clock, reset (async, active-low), flush (sync squash of all entries)
//   disp_*       : per-way dispatch payload. A tag operand carries the
//                  tag in its low TAG_W bits.
//   cdb_*        : CDB_NUM result broadcasts (valid, tag, data)
//   fu_*_avail   : per-issue-port FU availability (ALU / MULT / MEM)
//   iss_*        : registered issue payload. It is zero when iss_valid=0.
//   rs_free_cnt  : registered count of free entries
//   rs_full      : rs_free_cnt < WAYS. Dispatch is dropped while this is set.
module rs_nway #(
  parameter int RS_DEPTH = 16,
  parameter int WAYS     = 2,
  parameter int CDB_NUM  = 2,
  parameter int DATA_W   = 64,
  parameter int TAG_W    = 6,
  parameter int ROB_W    = 5,
  parameter int FUNC_W   = 5
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [WAYS-1:0]             disp_load,
  input  logic [WAYS*DATA_W-1:0]      disp_opa,
  input  logic [WAYS*DATA_W-1:0]      disp_opb,
  input  logic [WAYS-1:0]             disp_opa_valid,
  input  logic [WAYS-1:0]             disp_opb_valid,
  input  logic [WAYS*TAG_W-1:0]       disp_dest_tag,
  input  logic [WAYS*ROB_W-1:0]       disp_rob_idx,
  input  logic [WAYS*FUNC_W-1:0]      disp_func,
  input  logic [WAYS*2-1:0]           disp_class,
  input  logic [CDB_NUM-1:0]          cdb_valid,
  input  logic [CDB_NUM*TAG_W-1:0]    cdb_tag,
  input  logic [CDB_NUM*DATA_W-1:0]   cdb_data,
  input  logic [WAYS-1:0]             fu_alu_avail,
  input  logic [WAYS-1:0]             fu_mult_avail,
  input  logic [WAYS-1:0]             fu_mem_avail,
  output logic [WAYS-1:0]             iss_valid,
  output logic [WAYS*DATA_W-1:0]      iss_opa,
  output logic [WAYS*DATA_W-1:0]      iss_opb,
  output logic [WAYS*TAG_W-1:0]       iss_dest_tag,
  output logic [WAYS*ROB_W-1:0]       iss_rob_idx,
  output logic [WAYS*FUNC_W-1:0]      iss_func,
  output logic [WAYS*2-1:0]           iss_class,
  output logic [$clog2(RS_DEPTH):0]   rs_free_cnt,
  output logic                        rs_full
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // Returns {hit, data} for a tag against all CDBs.
  // The lowest-index matching CDB wins.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]          tag,
    input logic [CDB_NUM-1:0]        vld,
    input logic [CDB_NUM*TAG_W-1:0]  tags,
    input logic [CDB_NUM*DATA_W-1:0] data
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int c = CDB_NUM - 1; c >= 0; c--) begin
      if (vld[c] && tags[c*TAG_W +: TAG_W] == tag) begin
        res = {1'b1, data[c*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  // Entry storage. It is register-based because every entry is searched
  // every cycle.
  logic [RS_DEPTH-1:0] valid_reg;
  logic [RS_DEPTH-1:0] opa_rdy_reg;
  logic [RS_DEPTH-1:0] opb_rdy_reg;
  logic [DATA_W-1:0]   opa_reg   [RS_DEPTH];
  logic [DATA_W-1:0]   opb_reg   [RS_DEPTH];
  logic [TAG_W-1:0]    dest_reg  [RS_DEPTH];
  logic [ROB_W-1:0]    rob_reg   [RS_DEPTH];
  logic [FUNC_W-1:0]   func_reg  [RS_DEPTH];
  logic [1:0]          class_reg [RS_DEPTH];
`ifdef RS_AGE_PRIORITY_EN
  // Rank = number of valid entries older than this one (0 = oldest).
  logic [IDX_W-1:0]    age_reg   [RS_DEPTH];
  logic [IDX_W-1:0]    age_next  [RS_DEPTH];
  logic [IDX_W-1:0]    new_age   [WAYS];
  logic [IDX_W-1:0]    age_dec;
  logic [CNT_W-1:0]    age_base;
`endif

  logic [CNT_W-1:0]    rs_free_cnt_reg;

  logic [WAYS-1:0]                iss_valid_reg;
  logic [WAYS-1:0][DATA_W-1:0]    iss_opa_reg;
  logic [WAYS-1:0][DATA_W-1:0]    iss_opb_reg;
  logic [WAYS-1:0][TAG_W-1:0]     iss_dest_reg;
  logic [WAYS-1:0][ROB_W-1:0]     iss_rob_reg;
  logic [WAYS-1:0][FUNC_W-1:0]    iss_func_reg;
  logic [WAYS-1:0][1:0]           iss_class_reg;

  // Combinational helpers
  logic [DATA_W:0]     wa_res [RS_DEPTH];
  logic [DATA_W:0]     wb_res [RS_DEPTH];
  logic [DATA_W:0]     byp_a_res [WAYS];
  logic [DATA_W:0]     byp_b_res [WAYS];
  logic [DATA_W-1:0]   byp_opa [WAYS];
  logic [DATA_W-1:0]   byp_opb [WAYS];
  logic [WAYS-1:0]     byp_opa_rdy;
  logic [WAYS-1:0]     byp_opb_rdy;

  logic [RS_DEPTH-1:0] ready;
  logic [RS_DEPTH-1:0] taken;
  logic [WAYS-1:0]     sel_valid;
  logic [IDX_W-1:0]    sel_idx [WAYS];
  logic                sel_found;
  logic                cls_ok;

  logic                dispatch_ok;
  logic [RS_DEPTH-1:0] alloc_mask;
  logic [WAYS-1:0]     disp_go;
  logic [IDX_W-1:0]    disp_idx [WAYS];
  logic [CNT_W-1:0]    disp_cnt;
  logic [CNT_W-1:0]    iss_cnt;

  genvar gi;

  // Wakeup: compare each entry's stored tag against the CDBs.
  generate
    for (gi = 0; gi < RS_DEPTH; gi++) begin : g_wake
      assign wa_res[gi] = cdb_lookup(opa_reg[gi][TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
      assign wb_res[gi] = cdb_lookup(opb_reg[gi][TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
    end
  endgenerate

  // Dispatch bypass: a tag operand produced this very cycle is captured
  // directly.
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_byp
      assign byp_a_res[gi] = cdb_lookup(disp_opa[gi*DATA_W +: TAG_W], cdb_valid, cdb_tag, cdb_data);
      assign byp_b_res[gi] = cdb_lookup(disp_opb[gi*DATA_W +: TAG_W], cdb_valid, cdb_tag, cdb_data);
      assign byp_opa_rdy[gi] = disp_opa_valid[gi] | byp_a_res[gi][DATA_W];
      assign byp_opb_rdy[gi] = disp_opb_valid[gi] | byp_b_res[gi][DATA_W];
      assign byp_opa[gi] = (!disp_opa_valid[gi] && byp_a_res[gi][DATA_W]) ?
                           byp_a_res[gi][DATA_W-1:0] : disp_opa[gi*DATA_W +: DATA_W];
      assign byp_opb[gi] = (!disp_opb_valid[gi] && byp_b_res[gi][DATA_W]) ?
                           byp_b_res[gi][DATA_W-1:0] : disp_opb[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign ready       = valid_reg & opa_rdy_reg & opb_rdy_reg;
  assign rs_full     = (rs_free_cnt_reg < CNT_W'(WAYS));
  assign dispatch_ok = !rs_full && !flush;

  // Select: ports are served in order. Each port takes the best remaining
  // ready entry whose class has a free FU on that port. Class 3 is
  // treated as ALU.
  always_comb begin
    taken     = '0;
    sel_valid = '0;
    sel_found = 1'b0;
    cls_ok    = 1'b0;
    for (int p = 0; p < WAYS; p++) sel_idx[p] = '0;
    for (int p = 0; p < WAYS; p++) begin
      sel_found = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        cls_ok = (class_reg[i] == 2'd1) ? fu_mult_avail[p] :
                 (class_reg[i] == 2'd2) ? fu_mem_avail[p]  : fu_alu_avail[p];
        if (ready[i] && !taken[i] && cls_ok) begin
`ifdef RS_AGE_PRIORITY_EN
          if (!sel_found || age_reg[i] < age_reg[sel_idx[p]]) begin
`else
          if (!sel_found) begin
`endif
            sel_found  = 1'b1;
            sel_idx[p] = IDX_W'(i);
          end
        end
      end
      sel_valid[p] = sel_found;
      if (sel_found) taken[sel_idx[p]] = 1'b1;
    end
  end

  // Allocation: each loading way takes the lowest entry that was free at
  // the start of the cycle and was not claimed by a lower way.
  always_comb begin
    alloc_mask = '0;
    disp_go    = '0;
    for (int w = 0; w < WAYS; w++) disp_idx[w] = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (dispatch_ok && disp_load[w]) begin
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
          if (!valid_reg[i] && !alloc_mask[i]) begin
            disp_idx[w] = IDX_W'(i);
            disp_go[w]  = 1'b1;
          end
        end
        if (disp_go[w]) alloc_mask[disp_idx[w]] = 1'b1;
      end
    end
  end

  always_comb begin
    disp_cnt = '0;
    iss_cnt  = '0;
    for (int w = 0; w < WAYS; w++) begin
      disp_cnt = disp_cnt + CNT_W'(disp_go[w]);
      iss_cnt  = iss_cnt + CNT_W'(sel_valid[w]);
    end
  end

`ifdef RS_AGE_PRIORITY_EN
  // Survivors close the gaps left by issued older entries. New entries
  // rank behind all survivors, in way order.
  always_comb begin
    age_dec  = '0;
    age_base = CNT_W'(RS_DEPTH) - rs_free_cnt_reg - iss_cnt;
    for (int i = 0; i < RS_DEPTH; i++) begin
      age_dec = '0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (taken[j] && age_reg[j] < age_reg[i]) age_dec = age_dec + 1'b1;
      end
      age_next[i] = age_reg[i] - age_dec;
    end
    for (int w = 0; w < WAYS; w++) begin
      new_age[w] = age_base[IDX_W-1:0];
      if (disp_go[w]) age_base = age_base + 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_reg       <= '0;
      opa_rdy_reg     <= '0;
      opb_rdy_reg     <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        opa_reg[i]   <= '0;
        opb_reg[i]   <= '0;
        dest_reg[i]  <= '0;
        rob_reg[i]   <= '0;
        func_reg[i]  <= '0;
        class_reg[i] <= '0;
`ifdef RS_AGE_PRIORITY_EN
        age_reg[i]   <= '0;
`endif
      end
      rs_free_cnt_reg <= CNT_W'(RS_DEPTH);
      iss_valid_reg   <= '0;
      iss_opa_reg     <= '0;
      iss_opb_reg     <= '0;
      iss_dest_reg    <= '0;
      iss_rob_reg     <= '0;
      iss_func_reg    <= '0;
      iss_class_reg   <= '0;
    end else if (flush) begin
      valid_reg       <= '0;
      rs_free_cnt_reg <= CNT_W'(RS_DEPTH);
      iss_valid_reg   <= '0;
      iss_opa_reg     <= '0;
      iss_opb_reg     <= '0;
      iss_dest_reg    <= '0;
      iss_rob_reg     <= '0;
      iss_func_reg    <= '0;
      iss_class_reg   <= '0;
    end else begin
      // Wakeup of resident entries
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (valid_reg[i] && !opa_rdy_reg[i] && wa_res[i][DATA_W]) begin
          opa_reg[i]     <= wa_res[i][DATA_W-1:0];
          opa_rdy_reg[i] <= 1'b1;
        end
        if (valid_reg[i] && !opb_rdy_reg[i] && wb_res[i][DATA_W]) begin
          opb_reg[i]     <= wb_res[i][DATA_W-1:0];
          opb_rdy_reg[i] <= 1'b1;
        end
`ifdef RS_AGE_PRIORITY_EN
        age_reg[i] <= age_next[i];
`endif
      end

      // Dispatch writes only entries that were free at the start of the
      // cycle, so it never collides with the wakeup writes above.
      valid_reg <= (valid_reg & ~taken) | alloc_mask;
      for (int w = 0; w < WAYS; w++) begin
        if (disp_go[w]) begin
          opa_reg[disp_idx[w]]     <= byp_opa[w];
          opb_reg[disp_idx[w]]     <= byp_opb[w];
          opa_rdy_reg[disp_idx[w]] <= byp_opa_rdy[w];
          opb_rdy_reg[disp_idx[w]] <= byp_opb_rdy[w];
          dest_reg[disp_idx[w]]    <= disp_dest_tag[w*TAG_W +: TAG_W];
          rob_reg[disp_idx[w]]     <= disp_rob_idx[w*ROB_W +: ROB_W];
          func_reg[disp_idx[w]]    <= disp_func[w*FUNC_W +: FUNC_W];
          class_reg[disp_idx[w]]   <= disp_class[w*2 +: 2];
`ifdef RS_AGE_PRIORITY_EN
          age_reg[disp_idx[w]]     <= new_age[w];
`endif
        end
      end

      // Issue registers. The payload is forced to zero on idle ports.
      for (int p = 0; p < WAYS; p++) begin
        iss_valid_reg[p] <= sel_valid[p];
        if (sel_valid[p]) begin
          iss_opa_reg[p]   <= opa_reg[sel_idx[p]];
          iss_opb_reg[p]   <= opb_reg[sel_idx[p]];
          iss_dest_reg[p]  <= dest_reg[sel_idx[p]];
          iss_rob_reg[p]   <= rob_reg[sel_idx[p]];
          iss_func_reg[p]  <= func_reg[sel_idx[p]];
          iss_class_reg[p] <= class_reg[sel_idx[p]];
        end else begin
          iss_opa_reg[p]   <= '0;
          iss_opb_reg[p]   <= '0;
          iss_dest_reg[p]  <= '0;
          iss_rob_reg[p]   <= '0;
          iss_func_reg[p]  <= '0;
          iss_class_reg[p] <= '0;
        end
      end

      rs_free_cnt_reg <= rs_free_cnt_reg - disp_cnt + iss_cnt;
    end
  end

  assign iss_valid    = iss_valid_reg;
  assign iss_opa      = iss_opa_reg;
  assign iss_opb      = iss_opb_reg;
  assign iss_dest_tag = iss_dest_reg;
  assign iss_rob_idx  = iss_rob_reg;
  assign iss_func     = iss_func_reg;
  assign iss_class    = iss_class_reg;
  assign rs_free_cnt  = rs_free_cnt_reg;

endmodule

// File: tb/tb_rs_nway.sv
// Self-checking bench for rs_nway (default parameters).
// A slot-level behavioural model is stepped once per clock. DUT outputs
// are compared against it 1 time unit after each rising edge. The bench
// adds directed checks of fixed values from the test scenarios.
module tb_rs_nway;
  localparam int D  = 16;
  localparam int W  = 2;
  localparam int C  = 2;
  localparam int DW = 64;
  localparam int TW = 6;
  localparam int RW = 5;
  localparam int FW = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush;
  logic [W-1:0]    disp_load;
  logic [W*DW-1:0] disp_opa, disp_opb;
  logic [W-1:0]    disp_opa_valid, disp_opb_valid;
  logic [W*TW-1:0] disp_dest_tag;
  logic [W*RW-1:0] disp_rob_idx;
  logic [W*FW-1:0] disp_func;
  logic [W*2-1:0]  disp_class;
  logic [C-1:0]    cdb_valid;
  logic [C*TW-1:0] cdb_tag;
  logic [C*DW-1:0] cdb_data;
  logic [W-1:0]    fu_alu_avail, fu_mult_avail, fu_mem_avail;
  logic [W-1:0]    iss_valid;
  logic [W*DW-1:0] iss_opa, iss_opb;
  logic [W*TW-1:0] iss_dest_tag;
  logic [W*RW-1:0] iss_rob_idx;
  logic [W*FW-1:0] iss_func;
  logic [W*2-1:0]  iss_class;
  logic [4:0]      rs_free_cnt;
  logic            rs_full;

  rs_nway dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_load(disp_load), .disp_opa(disp_opa), .disp_opb(disp_opb),
    .disp_opa_valid(disp_opa_valid), .disp_opb_valid(disp_opb_valid),
    .disp_dest_tag(disp_dest_tag), .disp_rob_idx(disp_rob_idx),
    .disp_func(disp_func), .disp_class(disp_class),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_alu_avail(fu_alu_avail), .fu_mult_avail(fu_mult_avail), .fu_mem_avail(fu_mem_avail),
    .iss_valid(iss_valid), .iss_opa(iss_opa), .iss_opb(iss_opb),
    .iss_dest_tag(iss_dest_tag), .iss_rob_idx(iss_rob_idx),
    .iss_func(iss_func), .iss_class(iss_class),
    .rs_free_cnt(rs_free_cnt), .rs_full(rs_full)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit            v;
    logic [DW-1:0] a, b;
    bit            ar, br;
    logic [TW-1:0] dt;
    logic [RW-1:0] rob;
    logic [FW-1:0] fn;
    logic [1:0]    cl;
    int            seq;   // dispatch order stamp
  } ent_t;

  ent_t m [D];
  int   seq_ctr = 0;

  logic [W-1:0]    exp_valid;
  logic [W*DW-1:0] exp_opa, exp_opb;
  logic [W*TW-1:0] exp_dt;
  logic [W*RW-1:0] exp_rob;
  logic [W*FW-1:0] exp_fn;
  logic [W*2-1:0]  exp_cl;
  logic [4:0]      exp_free;
  logic            exp_full;

  task automatic model_reset();
    for (int i = 0; i < D; i++) m[i].v = 0;
  endtask

  function automatic bit port_has(input int p, input logic [1:0] cl);
    case (cl)
      2'd1:    return fu_mult_avail[p];
      2'd2:    return fu_mem_avail[p];
      default: return fu_alu_avail[p];
    endcase
  endfunction

  // True when slot i should win over slot j.
  function automatic bit higher_prio(input int i, input int j);
`ifdef RS_AGE_PRIORITY_EN
    return m[i].seq < m[j].seq;
`else
    return i < j;
`endif
  endfunction

  task automatic model_cdb(input logic [TW-1:0] tag, output bit hit, output logic [DW-1:0] d);
    hit = 0;
    d   = '0;
    for (int c = 0; c < C; c++) begin
      if (!hit && cdb_valid[c] && cdb_tag[c*TW +: TW] == tag) begin
        hit = 1;
        d   = cdb_data[c*DW +: DW];
      end
    end
  endtask

  task automatic model_step();
    bit rdy [D];
    bit tkn [D];
    bit vst [D];
    bit alc [D];
    int best, nvalid;
    bit hit;
    logic [DW-1:0] d;
    exp_valid = '0; exp_opa = '0; exp_opb = '0; exp_dt = '0;
    exp_rob = '0; exp_fn = '0; exp_cl = '0;
    for (int i = 0; i < D; i++) begin
      rdy[i] = m[i].v && m[i].ar && m[i].br;
      tkn[i] = 0;
      vst[i] = m[i].v;
      alc[i] = 0;
    end
    if (flush) begin
      model_reset();
    end else begin
      for (int p = 0; p < W; p++) begin
        best = -1;
        for (int i = 0; i < D; i++)
          if (rdy[i] && !tkn[i] && port_has(p, m[i].cl) && (best < 0 || higher_prio(i, best)))
            best = i;
        if (best >= 0) begin
          tkn[best] = 1;
          exp_valid[p] = 1'b1;
          exp_opa[p*DW +: DW] = m[best].a;
          exp_opb[p*DW +: DW] = m[best].b;
          exp_dt[p*TW +: TW]  = m[best].dt;
          exp_rob[p*RW +: RW] = m[best].rob;
          exp_fn[p*FW +: FW]  = m[best].fn;
          exp_cl[p*2 +: 2]    = m[best].cl;
        end
      end
      nvalid = 0;
      for (int i = 0; i < D; i++) if (vst[i]) nvalid++;
      for (int i = 0; i < D; i++) begin
        if (m[i].v) begin
          if (!m[i].ar) begin
            model_cdb(m[i].a[TW-1:0], hit, d);
            if (hit) begin m[i].a = d; m[i].ar = 1; end
          end
          if (!m[i].br) begin
            model_cdb(m[i].b[TW-1:0], hit, d);
            if (hit) begin m[i].b = d; m[i].br = 1; end
          end
          if (tkn[i]) m[i].v = 0;
        end
      end
      if (D - nvalid >= W) begin
        for (int w = 0; w < W; w++) begin
          if (disp_load[w]) begin
            best = -1;
            for (int i = 0; i < D; i++) if (best < 0 && !vst[i] && !alc[i]) best = i;
            alc[best] = 1;
            m[best].v   = 1;
            m[best].a   = disp_opa[w*DW +: DW];
            m[best].ar  = disp_opa_valid[w];
            m[best].b   = disp_opb[w*DW +: DW];
            m[best].br  = disp_opb_valid[w];
            if (!m[best].ar) begin
              model_cdb(m[best].a[TW-1:0], hit, d);
              if (hit) begin m[best].a = d; m[best].ar = 1; end
            end
            if (!m[best].br) begin
              model_cdb(m[best].b[TW-1:0], hit, d);
              if (hit) begin m[best].b = d; m[best].br = 1; end
            end
            m[best].dt  = disp_dest_tag[w*TW +: TW];
            m[best].rob = disp_rob_idx[w*RW +: RW];
            m[best].fn  = disp_func[w*FW +: FW];
            m[best].cl  = disp_class[w*2 +: 2];
            m[best].seq = seq_ctr;
            seq_ctr++;
          end
        end
      end
    end
    nvalid = 0;
    for (int i = 0; i < D; i++) if (m[i].v) nvalid++;
    exp_free = 5'(D - nvalid);
    exp_full = (D - nvalid) < W;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    flush = 0; disp_load = '0; disp_opa = '0; disp_opb = '0;
    disp_opa_valid = '0; disp_opb_valid = '0; disp_dest_tag = '0;
    disp_rob_idx = '0; disp_func = '0; disp_class = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic all_fu();
    fu_alu_avail = '1; fu_mult_avail = '1; fu_mem_avail = '1;
  endtask

  task automatic disp(input int w, input logic [1:0] cl, input logic [DW-1:0] a, input bit av,
                      input logic [DW-1:0] b, input bit bv, input logic [RW-1:0] rob,
                      input logic [TW-1:0] dt, input logic [FW-1:0] fn);
    disp_load[w] = 1'b1;
    disp_opa[w*DW +: DW] = a;   disp_opa_valid[w] = av;
    disp_opb[w*DW +: DW] = b;   disp_opb_valid[w] = bv;
    disp_rob_idx[w*RW +: RW] = rob;
    disp_dest_tag[w*TW +: TW] = dt;
    disp_func[w*FW +: FW] = fn;
    disp_class[w*2 +: 2] = cl;
  endtask

  task automatic cdb(input int c, input logic [TW-1:0] t, input logic [DW-1:0] d);
    cdb_valid[c] = 1'b1;
    cdb_tag[c*TW +: TW] = t;
    cdb_data[c*DW +: DW] = d;
  endtask

  // One clock: model, edge, compare everything, log issued instructions.
  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    cyc++;
    check("iss_valid", iss_valid, exp_valid);
    check("iss_opa", iss_opa, exp_opa);
    check("iss_opb", iss_opb, exp_opb);
    check("iss_dest_tag", iss_dest_tag, exp_dt);
    check("iss_rob_idx", iss_rob_idx, exp_rob);
    check("iss_func", iss_func, exp_fn);
    check("iss_class", iss_class, exp_cl);
    check("rs_free_cnt", rs_free_cnt, exp_free);
    check("rs_full", rs_full, exp_full);
    for (int p = 0; p < W; p++)
      if (exp_valid[p])
        $display("cycle %0d issue port %0d rob=%0d dest=%0d class=%0d opa=%0h opb=%0h",
                 cyc, p, exp_rob[p*RW +: RW], exp_dt[p*TW +: TW], exp_cl[p*2 +: 2],
                 exp_opa[p*DW +: DW], exp_opb[p*DW +: DW]);
  endtask

  localparam logic [1:0] ALU = 2'd0, MUL = 2'd1, MEM = 2'd2;

  initial begin
    idle();
    all_fu();
    model_reset();
    #12;
    check("rst_iss_valid", iss_valid, 0);
    check("rst_iss_opa", iss_opa, 0);
    check("rst_free", rs_free_cnt, 16);
    check("rst_full", rs_full, 0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Scenario 1/2: MULT issues next cycle; ALU waits for CDB tag 1.
    disp(0, MUL, 64'd32, 1, 64'd26, 1, 5'd0, 6'd1, 5'd3);
    disp(1, ALU, 64'd1, 0, 64'd46, 1, 5'd1, 6'd2, 5'd4);
    step();
    idle();
    cdb(0, 6'd1, 64'h340);
    step();
    check("t1_valid", iss_valid, 2'b01);
    check("t1_opa", iss_opa[63:0], 32);
    check("t1_opb", iss_opb[63:0], 26);
    check("t1_class", iss_class[1:0], 1);
    idle();
    step();
    check("t2_valid", iss_valid, 2'b01);
    check("t2_opa", iss_opa[63:0], 64'h340);
    check("t2_opb", iss_opb[63:0], 46);
    check("t2_rob", iss_rob_idx[4:0], 1);

    // Scenario 3: port-restricted FUs route MEM to port 1.
    fu_mult_avail = 2'b00;
    fu_mem_avail  = 2'b10;
    disp(0, MEM, 64'd7, 1, 64'd8, 1, 5'd2, 6'd3, 5'd1);
    disp(1, ALU, 64'd9, 1, 64'd10, 1, 5'd3, 6'd4, 5'd2);
    step();
    idle();
    step();
    check("t3_valid", iss_valid, 2'b11);
    check("t3_p0_rob", iss_rob_idx[4:0], 3);
    check("t3_p1_rob", iss_rob_idx[9:5], 2);
    check("t3_p1_class", iss_class[3:2], 2);
    all_fu();

    // Scenario 4: fill with dependents, then an overflow dispatch is dropped.
    for (int k = 0; k < 8; k++) begin
      idle();
      disp(0, ALU, 64'd50, 0, 64'd1, 1, 5'(2*k), 6'(k), 5'd0);
      disp(1, ALU, 64'd50, 0, 64'd2, 1, 5'(2*k+1), 6'(k), 5'd0);
      step();
    end
    check("t4_free", rs_free_cnt, 0);
    check("t4_full", rs_full, 1);
    step();   // same dispatch inputs held: must be ignored
    check("t4_free_hold", rs_free_cnt, 0);

    // Scenario 5: flush clears everything, including a same-cycle dispatch.
    idle(); flush = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      idle();
      disp(0, ALU, 64'd50, 0, 64'd1, 1, 5'(k), 6'd9, 5'd0);
      disp(1, MUL, 64'd50, 0, 64'd2, 1, 5'(k+8), 6'd9, 5'd0);
      step();
    end
    check("t5_pre_free", rs_free_cnt, 10);
    idle();
    flush = 1'b1;
    disp(0, ALU, 64'd11, 1, 64'd12, 1, 5'd20, 6'd5, 5'd1);
    disp(1, ALU, 64'd13, 1, 64'd14, 1, 5'd21, 6'd6, 5'd1);
    step();
    check("t5_free", rs_free_cnt, 16);
    check("t5_valid", iss_valid, 0);
    idle();
    cdb(0, 6'd50, 64'd5);
    step();
    idle();
    step();
    check("t5_quiet", iss_valid, 0);

    // Scenario 6: entry 5 older than re-dispatched entry 2, one ALU port.
    idle();
    disp(0, ALU, 64'd60, 0, 64'd1, 1, 5'd10, 6'd1, 5'd0);
    disp(1, ALU, 64'd60, 0, 64'd1, 1, 5'd11, 6'd1, 5'd0);
    step();
    idle();
    disp(0, ALU, 64'd5, 1, 64'd6, 1, 5'd12, 6'd1, 5'd0);
    disp(1, ALU, 64'd60, 0, 64'd1, 1, 5'd13, 6'd1, 5'd0);
    step();
    idle();
    disp(0, ALU, 64'd60, 0, 64'd1, 1, 5'd14, 6'd1, 5'd0);
    disp(1, ALU, 64'd61, 0, 64'd2, 1, 5'd21, 6'd1, 5'd0);
    step();
    check("t6_pre_rob", iss_rob_idx[4:0], 12);
    idle();
    disp(0, ALU, 64'd7, 1, 64'd8, 1, 5'd20, 6'd1, 5'd0);
    cdb(1, 6'd61, 64'h55);
    step();
    idle();
    fu_alu_avail = 2'b01;
    step();
`ifdef RS_AGE_PRIORITY_EN
    check("t6_first_rob", iss_rob_idx[4:0], 21);
`else
    check("t6_first_rob", iss_rob_idx[4:0], 20);
`endif
    step();
`ifdef RS_AGE_PRIORITY_EN
    check("t6_second_rob", iss_rob_idx[4:0], 20);
`else
    check("t6_second_rob", iss_rob_idx[4:0], 21);
`endif
    idle(); all_fu(); flush = 1'b1;
    step();

    // Randomised traffic with occasional flush and one async reset.
    for (int r = 0; r < 400; r++) begin
      idle();
      if (r == 200) begin
        #3;
        reset = 1'b0;
        #1;
        check("mr_valid", iss_valid, 0);
        check("mr_free", rs_free_cnt, 16);
        check("mr_full", rs_full, 0);
        model_reset();
        @(posedge clock); #1;
        reset = 1'b1;
      end
      for (int w = 0; w < W; w++) begin
        if ($urandom_range(0, 2) != 0) begin
          bit av, bv;
          logic [DW-1:0] a, b;
          av = $urandom_range(0, 2) != 0;
          bv = $urandom_range(0, 2) != 0;
          a = av ? {$urandom, $urandom} : 64'($urandom_range(1, 8));
          b = bv ? {$urandom, $urandom} : 64'($urandom_range(1, 8));
          disp(w, 2'($urandom_range(0, 3)), a, av, b, bv, 5'($urandom), 6'($urandom), 5'($urandom));
        end
      end
      for (int c = 0; c < C; c++)
        if ($urandom_range(0, 2) == 0) cdb(c, 6'($urandom_range(1, 8)), {$urandom, $urandom});
      fu_alu_avail  = 2'($urandom_range(0, 3));
      fu_mult_avail = 2'($urandom_range(0, 3));
      fu_mem_avail  = 2'($urandom_range(0, 3));
      flush = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rs_nway.md
# rs_nway

Parametrised N-way reservation station for the out-of-order core. Accepts up to `WAYS` renamed instructions per cycle from dispatch, captures operand results broadcast on `CDB_NUM` common data buses, and issues up to `WAYS` ready instructions per cycle to the functional-unit ports. Issue is gated by per-port functional-unit availability. Sits between rename/dispatch and the FU issue registers; generalises the fixed 2-way station to configurable depth, width and CDB count, and adds flush and a free-count output.

## Interface
- `RS_DEPTH`, 16: number of entries (power of 2, ≥ 2·`WAYS`)
- `WAYS`, 2: dispatch and issue width
- `CDB_NUM`, 2: number of CDB broadcast channels
- `DATA_W`, 64: operand width
- `TAG_W`, 6: PRF tag width
- `ROB_W`, 5: ROB index width
- `FUNC_W`, 5: ALU function code width
- `clock` in 1: the single clock; all state updates on the rising edge
- `reset` in 1: asynchronous, active-low; `0` clears all state immediately
- `flush` in 1: synchronous squash of every entry (branch mispredict)
- `disp_load` in `WAYS`: per-way dispatch valid
- `disp_opa`, `disp_opb` in `WAYS*DATA_W`: operand value, or tag in the low `TAG_W` bits when not valid
- `disp_opa_valid`, `disp_opb_valid` in `WAYS`: operand holds data (1) or a tag (0)
- `disp_dest_tag` in `WAYS*TAG_W`; `disp_rob_idx` in `WAYS*ROB_W`; `disp_func` in `WAYS*FUNC_W`
- `disp_class` in `WAYS*2`: 0 ALU, 1 MULT, 2 MEM, 3 reserved (treated as ALU)
- `cdb_valid` in `CDB_NUM`; `cdb_tag` in `CDB_NUM*TAG_W`; `cdb_data` in `CDB_NUM*DATA_W`
- `fu_alu_avail`, `fu_mult_avail`, `fu_mem_avail` in `WAYS`: per-issue-port FU availability
- `iss_valid` out `WAYS`; `iss_opa`, `iss_opb` out `WAYS*DATA_W`; `iss_dest_tag` out `WAYS*TAG_W`; `iss_rob_idx` out `WAYS*ROB_W`; `iss_func` out `WAYS*FUNC_W`; `iss_class` out `WAYS*2`
- `rs_free_cnt` out `$clog2(RS_DEPTH)+1`: registered count of free entries
- `rs_full` out 1: `rs_free_cnt < WAYS`

## Operation
- Entry fields: valid, opa/opb value, opa/opb ready, dest tag, ROB index, func, class, age.
- Dispatch: each way with `disp_load=1` takes the lowest-index free entry not taken by a lower way. Dispatch is accepted only when `rs_full=0`; otherwise all ways are dropped. Upstream must stall on `rs_full`.
- Dispatch bypass: a tag operand that matches a CDB broadcast in the same cycle is written as ready with the CDB data.
- Wakeup: each valid, not-ready operand compares its tag against every valid CDB. On a match it captures the data and sets ready at the edge. If tags duplicate, the lowest CDB index wins.
- Ready: entry valid and both operands ready at the start of the cycle. An entry woken at edge t is selectable in the cycle after t.
- Select: port 0 picks the highest-priority ready entry whose class FU is available on port 0. Port k picks the highest-priority ready entry not taken by ports < k whose class FU is available on port k.
- A selected entry is driven onto the issue registers and freed at the same edge.
- Flush: at the edge, all entries are invalidated and `iss_valid` is cleared. Same-cycle dispatch is discarded, and `rs_free_cnt` becomes `RS_DEPTH`. Flush takes priority over dispatch, wakeup and issue.

## Timing
- Reset values: every `iss_*` output is 0 (`iss_valid=0`), `rs_free_cnt=RS_DEPTH`, `rs_full=0`, and all entries are invalid.
- Dispatch → issue: an operand-ready instruction dispatched in cycle t is written at edge t. It is selected in cycle t+1 and `iss_valid` is high after edge t+1.
- CDB → issue: a broadcast in cycle t for the last missing operand gives `iss_valid` after edge t+1.
- `iss_valid` pulses for exactly one cycle per issued instruction. When `iss_valid=0`, the payload is 0.
- `rs_free_cnt` next = current − accepted dispatches + issued; it never underflows or overflows. Slots freed at edge t are usable by dispatch in cycle t+1.
- Simultaneous dispatch, wakeup and issue in one cycle are all honoured. A dispatched entry is never issued in its dispatch cycle.
- Reset mid-operation: all state clears asynchronously, and in-flight instructions are lost.

## Configuration
- `RS_AGE_PRIORITY_EN` defined: priority is oldest-first by dispatch order; within one dispatch group, lower way is older. Each entry keeps an age rank that is updated on dispatch and issue.
- Not defined: priority is lowest entry index first. The age field and its logic are removed.

## Test plan
- Reset, then dispatch way0 MULT (opa=32, opb=26, tag 1, rob 0) and way1 ALU (opa = tag 1 not ready, opb=46, rob 1), all FUs available → next cycle port 0 issues MULT with opa=32, opb=26; `iss_valid[1]=0`.
- In the same scenario, broadcast CDB0 tag 1 data 0x340 → one cycle later port 0 issues the ALU with opa=0x340, opb=46, rob 1.
- Dispatch MEM (rob 2) and ALU (rob 3), both ready, with `fu_mult_avail=0` and `fu_mem_avail[0]=0` → port 0 issues the ALU (rob 3) and port 1 issues the MEM (rob 2) in the same cycle.
- Fill to `RS_DEPTH` with tag-dependent entries → `rs_full=1` and `rs_free_cnt=0`; a further dispatch is ignored and the count is unchanged.
- Pre-load 6 entries, then assert `flush` together with a 2-way dispatch → after the edge, `rs_free_cnt=16`, `iss_valid=0`, and nothing issues afterward.
- With `RS_AGE_PRIORITY_EN`: entry 5 dispatched before entry 2, both ready, one ALU port → rob of entry 5 issues first. Without the macro → entry 2 issues first.
